// File: rtl/uk101_pkg.sv
// Shared definitions for the UK101 file-load path: the feeder FSM states and
// the ASCII control codes the line-ending filter has to recognise.
package uk101_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        FEED_IDLE    = 2'd0,
        FEED_POP     = 2'd1,
        FEED_PRESENT = 2'd2,
        FEED_GAP     = 2'd3
    } feed_state_t;

    localparam byte_t ASCII_NUL = 8'h00;
    localparam byte_t ASCII_LF  = 8'h0A;
    localparam byte_t ASCII_CR  = 8'h0D;
    localparam byte_t ASCII_SUB = 8'h1A;

    // NUL padding and the CP/M-style EOF marker never reach the ACIA.
    function automatic logic is_dropped(input byte_t b);
        return (b == ASCII_NUL) || (b == ASCII_SUB);
    endfunction

endpackage

// File: rtl/ioctl_ascii_feeder_if.sv
// Bus bundle between hps_io (ioctl write side), the feeder, and the ACIA
// receive side. The feeder is the slave; the surrounding system is the master.
interface ioctl_ascii_feeder_if;
    import uk101_pkg::*;

    logic  ioctl_download;
    logic  ioctl_wr;
    byte_t ioctl_data;
    logic  ioctl_wait;
    logic  rx_valid;
    byte_t rx_data;
    logic  rx_ready;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_data, rx_ready,
        input  ioctl_wait, rx_valid, rx_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_data, rx_ready,
        output ioctl_wait, rx_valid, rx_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit for full/empty, synchronous
// flush and a registered read port. rd_data shows the entry at the head as
// of the previous clock, so a consumer must let one cycle pass between a pop
// and using the next head.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_data_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = rd_data_reg;

    // Pointer update; flush empties the buffer and wins over push/pop.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    // Registered read of the current head.
    always_ff @(posedge clk) begin
        rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

endmodule

// File: rtl/ioctl_ascii_feeder.sv
// Paced feeder: buffers "Load Ascii" download bytes from hps_io, throttles the
// HPS with ioctl_wait, folds CR/LF/CRLF line endings into CR, drops NUL/EOF,
// and offers one character at a time to the ACIA with an inter-character gap
// the monitor/BASIC can keep up with.
module ioctl_ascii_feeder
    import uk101_pkg::*;
#(
    parameter int CLK_HZ     = 48_000_000,
    parameter int DEPTH      = 16,
    parameter int GAP_FAST   = CLK_HZ / 960,
    parameter int GAP_SLOW   = CLK_HZ / 30,
    parameter int LINE_EXTRA = CLK_HZ / 50
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  enable,
    input  logic                  baud_rate,
    ioctl_ascii_feeder_if.slave   bus,
    output logic                  busy,
    output logic                  overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP_SLOW + LINE_EXTRA + 1);

    feed_state_t    state_reg;
    feed_state_t    state_next;
    logic           download_prev_reg;
    logic           flush;
    logic           push_req;
    logic           pop;
    logic           gap_load;
    logic [GW-1:0]  gap_cnt_reg;
    logic [GW-1:0]  gap_load_val;
    logic           prev_cr_reg;
    logic           prev_cr_next;
    byte_t          rx_data_reg;
    logic           wait_reg;
    logic           overflow_reg;
    logic           emit;
    byte_t          emit_byte;
    byte_t          fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    // A new download starts on the rising edge of ioctl_download.
    assign flush    = bus.ioctl_download && !download_prev_reg;
    assign push_req = bus.ioctl_wr && bus.ioctl_download && enable;

    assign bus.rx_data    = rx_data_reg;
    assign bus.ioctl_wait = wait_reg;
    assign overflow       = overflow_reg;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .flush   (flush),
        .push    (push_req && !flush),
        .wr_data (bus.ioctl_data),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Remember the previous download level for edge detection.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) download_prev_reg <= 1'b0;
        else          download_prev_reg <= bus.ioctl_download;
    end

    // Line-ending filter on the FIFO head: CR passes, LF after CR vanishes,
    // a bare LF becomes CR, NUL/EOF vanish without touching the CR memory.
    always_comb begin
        emit         = 1'b1;
        emit_byte    = fifo_head;
        prev_cr_next = 1'b0;
        if (is_dropped(fifo_head)) begin
            emit         = 1'b0;
            prev_cr_next = prev_cr_reg;
        end else if (fifo_head == ASCII_CR) begin
            prev_cr_next = 1'b1;
        end else if (fifo_head == ASCII_LF) begin
            if (prev_cr_reg) emit = 1'b0;
            else             emit_byte = ASCII_CR;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_reg <= FEED_IDLE;
        else          state_reg <= state_next;
    end

    // FSM next-state logic; a new download always restarts from IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FEED_IDLE:    if (!fifo_empty && enable) state_next = FEED_POP;
            FEED_POP:     state_next = emit ? FEED_PRESENT : FEED_IDLE;
            FEED_PRESENT: if (bus.rx_ready) state_next = FEED_GAP;
            FEED_GAP:     if (gap_cnt_reg <= GW'(1)) state_next = FEED_IDLE;
            default:      state_next = FEED_IDLE;
        endcase
        if (flush) state_next = FEED_IDLE;
    end

    // FSM outputs.
    always_comb begin
        pop          = (state_reg == FEED_POP) && !flush;
        gap_load     = (state_reg == FEED_PRESENT) && bus.rx_ready;
        bus.rx_valid = (state_reg == FEED_PRESENT);
        busy         = !fifo_empty || (state_reg != FEED_IDLE);
    end

    // Gap length for the character just accepted. The handshake cycle is the
    // first gap cycle, hence the -1; the character after a CR gets extra
    // time so the interpreter can finish processing the line.
    always_comb begin
        gap_load_val = baud_rate ? GW'(GAP_SLOW - 1) : GW'(GAP_FAST - 1);
        if (rx_data_reg == ASCII_CR) gap_load_val = gap_load_val + GW'(LINE_EXTRA);
    end

    // Inter-character gap counter; baud_rate only matters at load time.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            gap_cnt_reg <= '0;
        else if (gap_load)
            gap_cnt_reg <= gap_load_val;
        else if (state_reg == FEED_GAP && gap_cnt_reg != '0)
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
    end

    // Character register and CR memory, updated when the head is popped.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_data_reg <= ASCII_NUL;
            prev_cr_reg <= 1'b0;
        end else if (flush) begin
            prev_cr_reg <= 1'b0;
        end else if (pop) begin
            prev_cr_reg <= prev_cr_next;
            if (emit) rx_data_reg <= emit_byte;
        end
    end

    // HPS stall with two entries of slack, and sticky lost-write flag.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wait_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wait_reg <= (fifo_count >= CW'(DEPTH - 2));
            if (flush)
                overflow_reg <= 1'b0;
            else if (push_req && fifo_full)
                overflow_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ioctl_ascii_feeder.sv
// Directed bench for ioctl_ascii_feeder with shortened gaps
// (fast 20, slow 60, extra-after-CR 30 cycles, 16-entry FIFO).
module tb_ioctl_ascii_feeder;
    import uk101_pkg::*;

    localparam int DEPTH  = 16;
    localparam int G_FAST = 20;
    localparam int G_SLOW = 60;
    localparam int EXTRA  = 30;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic enable = 1'b0;
    logic baud_rate = 1'b0;
    logic busy;
    logic overflow;

    ioctl_ascii_feeder_if bus();

    ioctl_ascii_feeder #(
        .CLK_HZ     (48_000_000),
        .DEPTH      (DEPTH),
        .GAP_FAST   (G_FAST),
        .GAP_SLOW   (G_SLOW),
        .LINE_EXTRA (EXTRA)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .enable    (enable),
        .baud_rate (baud_rate),
        .bus       (bus),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    byte_t rx_q[$];
    int    rx_t[$];

    // Record every accepted character with the cycle it was accepted in.
    always @(negedge clk) begin
        if (n_reset && bus.rx_valid && bus.rx_ready) begin
            rx_q.push_back(bus.rx_data);
            rx_t.push_back(cyc);
            $display("rx byte=0x%02h cycle=%0d", bus.rx_data, cyc);
        end
    end

    int    checks = 0;
    int    failures = 0;
    int    last_wr_cyc = 0;
    int    first_cyc = 0;
    int    first_wait = -1;
    int    nlf = 0;
    byte_t b;
    string line1 = "10 PRINT 1";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One write strobe, no regard for ioctl_wait.
    task automatic wr1(input byte_t d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_data = d;
        last_wr_cyc    = cyc;
        step(1);
        bus.ioctl_wr   = 1'b0;
        $display("wr byte=0x%02h cycle=%0d", d, last_wr_cyc);
    endtask

    // Write strobe from an HPS that honours ioctl_wait.
    task automatic wr_honour(input byte_t d);
        int k = 0;
        while (bus.ioctl_wait === 1'b1 && k < 1000) begin
            step(1);
            k++;
        end
        chk("wait_release", {31'd0, bus.ioctl_wait}, 32'd0);
        wr1(d);
    endtask

    task automatic start_download();
        bus.ioctl_download = 1'b0;
        step(1);
        bus.ioctl_download = 1'b1;
        step(1);
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, {31'd0, rx_q.size() >= n}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_data     = 8'h00;
        bus.rx_ready       = 1'b1;

        // Reset state
        step(3);
        chk("rst_wait",     {31'd0, bus.ioctl_wait}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid},   32'd0);
        chk("rst_rx_data",  {24'd0, bus.rx_data},    32'd0);
        chk("rst_busy",     {31'd0, busy},           32'd0);
        chk("rst_overflow", {31'd0, overflow},       32'd0);
        n_reset = 1'b1;
        enable  = 1'b1;
        step(2);

        // "10 PRINT 1" CR LF at 9600 baud
        start_download();
        for (int i = 0; i < line1.len(); i++) begin
            wr_honour(byte_t'(line1[i]));
            if (i == 0) first_cyc = last_wr_cyc;
        end
        wr_honour(ASCII_CR);
        wr_honour(ASCII_LF);
        wait_rx(11, 800, "t1_rx_timeout");
        step(100);
        chk("t1_count", rx_q.size(), 32'd11);
        chk("t1_latency", rx_t[0] - first_cyc, 32'd3);
        for (int i = 0; i < 10; i++) begin
            b = byte_t'(line1[i]);
            chk("t1_byte", {24'd0, rx_q[i]}, {24'd0, b});
        end
        chk("t1_last_cr", {24'd0, rx_q[10]}, 32'h0D);
        nlf = 0;
        foreach (rx_q[i]) if (rx_q[i] == ASCII_LF) nlf++;
        chk("t1_no_lf", nlf, 32'd0);
        for (int i = 1; i < 11; i++) chk("t1_spacing", rx_t[i] - rx_t[i-1], G_FAST + 2);

        // 20-byte burst into a stalled ACIA, HPS honours wait
        bus.rx_ready = 1'b0;
        start_download();
        for (int i = 0; i < 20; i++) begin
            if (bus.ioctl_wait === 1'b1 && bus.rx_ready === 1'b0) begin
                first_wait = i;
                step(3);
                chk("t2_no_overflow", {31'd0, overflow}, 32'd0);
                chk("t2_busy", {31'd0, busy}, 32'd1);
                bus.rx_ready = 1'b1;
            end
            wr_honour(byte_t'(8'h61 + i));
        end
        chk("t2_wait_after_n_writes", first_wait, 32'd16);
        wait_rx(20, 1500, "t2_rx_timeout");
        chk("t2_overflow_end", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 20; i++) chk("t2_order", {24'd0, rx_q[i]}, 32'h61 + i);

        // Ignore wait: one byte presenting, then 18 writes -> 16 kept, 2 lost
        bus.rx_ready = 1'b0;
        start_download();
        wr1(8'h21);
        step(4);
        for (int i = 0; i < 18; i++) wr1(byte_t'(8'h41 + i));
        step(2);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        bus.rx_ready = 1'b1;
        wait_rx(17, 1000, "t3_rx_timeout");
        step(100);
        chk("t3_count", rx_q.size(), 32'd17);
        chk("t3_first", {24'd0, rx_q[0]}, 32'h21);
        for (int i = 1; i < 17; i++) chk("t3_order", {24'd0, rx_q[i]}, 32'h41 + i - 1);
        chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Unix line endings
        start_download();
        chk("t4_overflow_cleared", {31'd0, overflow}, 32'd0);
        wr1(8'h41); wr1(ASCII_LF); wr1(8'h42); wr1(ASCII_LF);
        wait_rx(4, 600, "t4_rx_timeout");
        step(100);
        chk("t4_count", rx_q.size(), 32'd4);
        chk("t4_b0", {24'd0, rx_q[0]}, 32'h41);
        chk("t4_b1", {24'd0, rx_q[1]}, 32'h0D);
        chk("t4_b2", {24'd0, rx_q[2]}, 32'h42);
        chk("t4_b3", {24'd0, rx_q[3]}, 32'h0D);
        chk("t4_spacing", rx_t[1] - rx_t[0], G_FAST + 2);
        chk("t4_spacing_cr", rx_t[2] - rx_t[1], G_FAST + EXTRA + 2);

        // NUL and EOF are dropped, CR LF collapses to CR
        start_download();
        wr1(8'h43); wr1(ASCII_NUL); wr1(8'h44); wr1(ASCII_SUB); wr1(ASCII_CR); wr1(ASCII_LF);
        wait_rx(3, 600, "t4b_rx_timeout");
        step(100);
        chk("t4b_count", rx_q.size(), 32'd3);
        chk("t4b_b0", {24'd0, rx_q[0]}, 32'h43);
        chk("t4b_b1", {24'd0, rx_q[1]}, 32'h44);
        chk("t4b_b2", {24'd0, rx_q[2]}, 32'h0D);

        // New download while presenting with 5 bytes queued
        bus.rx_ready = 1'b0;
        start_download();
        for (int i = 0; i < 6; i++) wr1(byte_t'(8'h70 + i));
        step(3);
        chk("t5_valid_before", {31'd0, bus.rx_valid}, 32'd1);
        chk("t5_data_before", {24'd0, bus.rx_data}, 32'h70);
        bus.ioctl_download = 1'b0;
        step(1);
        chk("t5_valid_held", {31'd0, bus.rx_valid}, 32'd1);
        bus.ioctl_download = 1'b1;
        step(1);
        chk("t5_valid_dropped", {31'd0, bus.rx_valid}, 32'd0);
        chk("t5_busy_flushed", {31'd0, busy}, 32'd0);
        rx_q.delete();
        rx_t.delete();
        bus.rx_ready = 1'b1;
        wr1(8'h58); wr1(8'h59);
        wait_rx(2, 300, "t5_rx_timeout");
        step(100);
        chk("t5_count", rx_q.size(), 32'd2);
        chk("t5_b0", {24'd0, rx_q[0]}, 32'h58);
        chk("t5_b1", {24'd0, rx_q[1]}, 32'h59);

        // baud_rate change mid-gap affects only the next gap
        baud_rate = 1'b0;
        start_download();
        wr1(8'h4A); wr1(8'h4B); wr1(8'h4C);
        wait_rx(1, 100, "t6_first_timeout");
        step(5);
        baud_rate = 1'b1;
        wait_rx(3, 400, "t6_rx_timeout");
        chk("t6_gap_unchanged", rx_t[1] - rx_t[0], G_FAST + 2);
        chk("t6_gap_slow", rx_t[2] - rx_t[1], G_SLOW + 2);
        chk("t6_b2", {24'd0, rx_q[2]}, 32'h4C);

        // Fill and overrun during the slow gap, then reset asynchronously
        for (int i = 0; i < 17; i++) wr1(byte_t'(8'h30 + i));
        step(2);
        chk("t6_overflow", {31'd0, overflow}, 32'd1);
        chk("t6_wait", {31'd0, bus.ioctl_wait}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("arst_wait",     {31'd0, bus.ioctl_wait}, 32'd0);
        chk("arst_rx_valid", {31'd0, bus.rx_valid},   32'd0);
        chk("arst_rx_data",  {24'd0, bus.rx_data},    32'd0);
        chk("arst_busy",     {31'd0, busy},           32'd0);
        chk("arst_overflow", {31'd0, overflow},       32'd0);
        step(2);
        n_reset = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
